// File: rtl/enc_pkg.sv
// Shared types, sizes and helpers for the scanning 8-to-3 encoder.
package enc_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic pop_is_one(input logic [ENC_N-1:0] v);
        logic [ENC_N-1:0] v_minus_one;
        v_minus_one = v - {{(ENC_N-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & v_minus_one) == '0);
    endfunction

endpackage

// File: rtl/find_first_set.sv
// Combinational lowest-set-bit finder; resolves in a single cycle.
module find_first_set #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_8x3_scan.sv
// Sequential 8-to-3 encoder: emits the index of every set request bit,
// lowest first, one beat per cycle; an all-zero vector yields one "none" beat.
module encoder_8x3_scan
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_last,
    output logic         out_none
);

    state_t         state;
    logic [N-1:0]   pending;
    logic           zero_flag;
    logic [W-1:0]   ffs_idx;
    logic           ffs_any;
    logic           emit;

    find_first_set #(.N(N), .W(W)) u_ffs (
        .vec (pending),
        .idx (ffs_idx),
        .any (ffs_any)
    );

    // Beat fields decode from registered state only; all zero outside EMIT.
    always_comb begin
        emit      = (state == ST_EMIT);
        out_valid = emit;
        out_code  = (emit && !zero_flag && ffs_any) ? ffs_idx : '0;
        out_last  = emit && (zero_flag || pop_is_one(ENC_N'(pending)));
        out_none  = emit && zero_flag;
        // A new vector may land in the same cycle the final beat leaves.
        in_ready  = !emit || (out_ready && out_last);
    end

    // Control FSM and pending-bit datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        pending   <= in_req;
                        zero_flag <= (in_req == '0);
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            if (in_valid) begin
                                pending   <= in_req;
                                zero_flag <= (in_req == '0);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            pending[out_code] <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_scan.sv
// Bench for encoder_8x3_scan: queue-of-beats reference model with a per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_encoder_8x3_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_req = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_code;
    logic       out_last;
    logic       out_none;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] code;
        logic       last;
        logic       none;
    } beat_t;

    beat_t q[$];

    encoder_8x3_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Every accepted vector becomes its list of expected beats.
    function automatic void push_vec(input logic [7:0] v);
        beat_t b;
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        if (n == 0) begin
            b.code = 3'd0; b.last = 1'b1; b.none = 1'b1;
            q.push_back(b);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    n--;
                    b.code = 3'(i); b.last = (n == 0); b.none = 1'b0;
                    q.push_back(b);
                end
            end
        end
    endfunction

    function automatic logic model_ready();
        return (q.size() == 0) || (out_ready && q[0].last);
    endfunction

    // Reference model state update.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            logic acc;
            acc = in_valid && model_ready();
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) push_vec(in_req);
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_in_ready", 32'(in_ready), 32'(model_ready()));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_code", 32'(out_code), 32'(q[0].code));
                chk("m_last", 32'(out_last), 32'(q[0].last));
                chk("m_none", 32'(out_none), 32'(q[0].none));
            end
        end
    end

    // Present a vector and wait until it is accepted (bounded).
    task automatic send(input logic [7:0] v);
        bit done = 0;
        in_req = v;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int bp_codes[11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
        logic [7:0] dec;

        // Reset state
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fields", {29'd0, out_code}, 32'd0);
        chk("rst_flags", {30'd0, out_last, out_none}, 32'd0);
        step();

        // One-hot sweep with decoder round trip
        for (int k = 0; k < 8; k++) begin
            send(8'(1 << k));
            @(negedge clk);
            dec = 8'b1 << out_code;
            chk("sweep_code", 32'(out_code), 32'(k));
            chk("sweep_decode", 32'(dec), 32'(1 << k));
            chk("sweep_last_none", {30'd0, out_last, out_none}, 32'b10);
            step();
        end

        // Multi-hot 1010_0100
        send(8'b1010_0100);
        @(negedge clk);
        chk("mh_b0", {27'd0, out_code, out_last, in_ready}, {27'd0, 3'd2, 1'b0, 1'b0});
        step(); @(negedge clk);
        chk("mh_b1", {27'd0, out_code, out_last, in_ready}, {27'd0, 3'd5, 1'b0, 1'b0});
        step(); @(negedge clk);
        chk("mh_b2", {27'd0, out_code, out_last, in_ready}, {27'd0, 3'd7, 1'b1, 1'b1});
        step();

        // Zero vector
        send(8'h00);
        @(negedge clk);
        chk("zero_beat", {26'd0, out_valid, out_code, out_last, out_none}, {26'd0, 1'b1, 3'd0, 1'b1, 1'b1});
        step(); @(negedge clk);
        chk("zero_idle", 32'(out_valid), 32'd0);
        step();

        // Backpressure on beat 3 of 8'hFF
        send(8'hFF);
        for (int i = 0; i < 11; i++) begin
            out_ready = !(i >= 3 && i <= 5);
            @(negedge clk);
            chk("bp_code", 32'(out_code), 32'(bp_codes[i]));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", 32'(out_valid), 32'd0);
        step();

        // Back-to-back 8'h81 then 8'h10
        in_req = 8'h81; in_valid = 1'b1;
        step();
        in_req = 8'h10;
        @(negedge clk);
        chk("b2b_0", {28'd0, out_code, in_ready}, {28'd0, 3'd0, 1'b0});
        step(); @(negedge clk);
        chk("b2b_7", {28'd0, out_code, in_ready}, {28'd0, 3'd7, 1'b1});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_4", {28'd0, out_code, out_last}, {28'd0, 3'd4, 1'b1});
        step();

        // Reset mid-EMIT
        send(8'hF0);
        @(negedge clk);
        chk("rm_b4", 32'(out_code), 32'd4);
        step(); @(negedge clk);
        chk("rm_b5", 32'(out_code), 32'd5);
        #2 rst_n = 1'b0;
        #1 chk("rm_in_rst", {26'd0, out_valid, out_code, out_last, out_none}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rm_after", {25'd0, out_valid, out_code, out_last, out_none, in_ready}, 32'd1);
        step();
        send(8'h02);
        @(negedge clk);
        chk("rm_new", {28'd0, out_code, out_last}, {28'd0, 3'd1, 1'b1});
        step(); @(negedge clk);
        chk("rm_new_done", 32'(out_valid), 32'd0);
        step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: in_req = 8'h00;
                1: in_req = 8'(1 << $urandom_range(0, 7));
                default: in_req = 8'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
